// File: rtl/sdf_butterfly_r2_if.sv
// Streaming bus of the radix-2 SDF butterfly stage: one complex sample in,
// one complex butterfly result out, no backpressure.
interface sdf_butterfly_r2_if #(
    parameter int unsigned NBITS     = 12,
    parameter int unsigned NBITS_out = NBITS + 1
) ();

    localparam int unsigned IN_W  = 2 * NBITS;
    localparam int unsigned OUT_W = 2 * NBITS_out;

    logic             in_valid;
    logic [IN_W-1:0]  muestra;
    logic             out_valid;
    logic             out_first;
    logic [OUT_W-1:0] result;

    // Upstream side: drives samples, observes butterfly results
    modport master (
        output in_valid,
        output muestra,
        input  out_valid,
        input  out_first,
        input  result
    );

    // Butterfly side: consumes samples, produces results
    modport slave (
        input  in_valid,
        input  muestra,
        output out_valid,
        output out_first,
        output result
    );

endinterface

// File: rtl/sdf_butterfly_r2.sv
// Radix-2 single-delay-feedback DIF butterfly stage.
// Phase 0 of a frame stores incoming samples and replays the previous frame's
// differences; phase 1 emits sums and stores the differences for later.
module sdf_butterfly_r2 #(
    parameter int unsigned NBITS     = 12,
    parameter int unsigned DELAY     = 4,
    parameter int unsigned NBITS_out = NBITS + 1
) (
    input  logic               clk,
    input  logic               rst,
    sdf_butterfly_r2_if.slave  bus
);

    localparam int unsigned FRAME = 2 * DELAY;
    localparam int unsigned CNT_W = $clog2(FRAME);
    localparam int unsigned IN_W  = 2 * NBITS;
    localparam int unsigned OUT_W = 2 * NBITS_out;

    // Frame position; DELAY is a power of two so the counter wraps naturally
    logic [CNT_W-1:0] cnt;

    // Feedback delay line, real and imaginary parts kept separately
    logic signed [NBITS_out-1:0] dl_re [DELAY];
    logic signed [NBITS_out-1:0] dl_im [DELAY];

    // Set once the first full frame has been seen; phase 0 outputs then carry real diffs
    logic diff_pending;

    logic             out_valid_q;
    logic             out_first_q;
    logic [OUT_W-1:0] result_q;

    logic                        phase1_c;
    logic                        last_c;
    logic                        first_c;
    logic                        valid_c;
    logic signed [NBITS_out-1:0] x_re_c;
    logic signed [NBITS_out-1:0] x_im_c;
    logic signed [NBITS_out-1:0] old_re_c;
    logic signed [NBITS_out-1:0] old_im_c;
    logic signed [NBITS_out-1:0] push_re_c;
    logic signed [NBITS_out-1:0] push_im_c;
    logic signed [NBITS_out-1:0] res_re_c;
    logic signed [NBITS_out-1:0] res_im_c;

    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.result    = result_q;

    // Butterfly datapath: select what enters the delay line and what leaves the stage
    always_comb begin
        phase1_c  = 1'b0;
        last_c    = 1'b0;
        first_c   = 1'b0;
        valid_c   = 1'b0;
        x_re_c    = '0;
        x_im_c    = '0;
        old_re_c  = '0;
        old_im_c  = '0;
        push_re_c = '0;
        push_im_c = '0;
        res_re_c  = '0;
        res_im_c  = '0;

        phase1_c = (cnt >= CNT_W'(DELAY));
        last_c   = (cnt == CNT_W'(FRAME - 1));
        first_c  = (cnt == CNT_W'(DELAY));
        valid_c  = phase1_c | diff_pending;

        x_re_c   = NBITS_out'($signed(bus.muestra[IN_W-1 -: NBITS]));
        x_im_c   = NBITS_out'($signed(bus.muestra[NBITS-1:0]));
        old_re_c = dl_re[DELAY-1];
        old_im_c = dl_im[DELAY-1];

        if (phase1_c) begin
            push_re_c = old_re_c - x_re_c;
            push_im_c = old_im_c - x_im_c;
            res_re_c  = old_re_c + x_re_c;
            res_im_c  = old_im_c + x_im_c;
        end else begin
            push_re_c = x_re_c;
            push_im_c = x_im_c;
            res_re_c  = old_re_c;
            res_im_c  = old_im_c;
        end
    end

    // Frame counter and pending-difference flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            diff_pending <= 1'b0;
        end else if (bus.in_valid) begin
            cnt <= cnt + CNT_W'(1);
            if (last_c) begin
                diff_pending <= 1'b1;
            end
        end
    end

    // Feedback delay line shifts once per accepted sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                dl_re[i] <= '0;
                dl_im[i] <= '0;
            end
        end else if (bus.in_valid) begin
            dl_re[0] <= push_re_c;
            dl_im[0] <= push_im_c;
            for (int unsigned i = 1; i < DELAY; i++) begin
                dl_re[i] <= dl_re[i-1];
                dl_im[i] <= dl_im[i-1];
            end
        end
    end

    // Registered outputs; result holds its value while the input is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= bus.in_valid & valid_c;
            out_first_q <= bus.in_valid & first_c;
            if (bus.in_valid) begin
                result_q <= {res_re_c, res_im_c};
            end
        end
    end

endmodule

// File: doc/sdf_butterfly_r2.md
# sdf_butterfly_r2

Radix-2 single-delay-feedback (SDF) DIF butterfly stage for the 128-point pipelined FFT. It consumes one complex sample per accepted cycle and combines each sample with the one DELAY positions earlier through an internal feedback delay line. It emits sums and differences in natural SDF order, with one bit of growth. It sits directly upstream of the CSD twiddle multiplier stage and feeds its `muestra` input.

## Interface
- `NBITS`, 12, width of each real/imag input component (signed two's complement)
- `DELAY`, 4, feedback depth in samples; power of two, ≥2; frame length is 2·DELAY
- `NBITS_out`, NBITS+1, width of each output component
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `muestra` is valid this cycle; the stage advances only when high
- `muestra`  in  2·NBITS  {real, imag}; real in the upper NBITS bits
- `out_valid`  out  1  `result` holds a valid butterfly output
- `out_first`  out  1  high with the first sum of each frame; used to synchronise the downstream twiddle counter
- `result`  out  2·NBITS_out  {real, imag}; real in the upper NBITS_out bits

## Operation
- State:
  - sample counter `cnt`, 0..2·DELAY−1, advances on each accepted sample and wraps
  - delay line `dl[0..DELAY−1]` of complex NBITS_out-bit entries, shifting on each accepted sample
  - flag `diff_pending`
- Accepted sample x, with dl_out = dl[DELAY−1] (the oldest entry):
  - Phase 0, cnt < DELAY:
    - push sign-extended x into the delay line
    - output dl_out, i.e. the difference from the previous frame
    - output is valid only if `diff_pending` = 1
  - Phase 1, cnt ≥ DELAY:
    - output sum = dl_out + x; always valid
    - push diff = dl_out − x into the delay line
- Arithmetic:
  - real and imag are handled independently
  - operands are sign-extended to NBITS_out before add/sub
  - no rounding or saturation; the result cannot overflow NBITS_out
- `diff_pending` is set on the accepted sample with cnt = 2·DELAY−1. It stays set until reset.
- Stream stop: differences of the last frame remain in the delay line until the next frame's phase 0 pushes them out. No flush mechanism exists.
- `in_valid` = 0: no state changes. `out_valid` drops to 0 next cycle. `result` holds its last value.
- `out_first` = 1 on the output produced by the accepted sample with cnt = DELAY.

## Timing
- Reset (`rst` low, asynchronous):
  - `cnt` = 0, all `dl` entries = 0, `diff_pending` = 0
  - `result` = 0, `out_valid` = 0, `out_first` = 0
- Outputs are registered, one cycle after the accepted input:
  - `out_valid`(t+1) = `in_valid`(t) & (phase1 | `diff_pending`)
- Latency:
  - sum of pair (x[k], x[k+DELAY]): 1 cycle after x[k+DELAY] is accepted
  - matching difference: emerges DELAY accepted samples later, during the next frame's phase 0
- Output order per steady-state frame: DELAY differences of the previous frame, then DELAY sums of the current frame.
- Reset mid-frame: all partial data is discarded. The next accepted sample is cnt = 0 of a fresh first frame, so its phase 0 produces no valid outputs.
- Full throughput of one sample per clock. There is no backpressure input, so the downstream stage must accept every `out_valid` cycle.

## Test plan
All cases use NBITS = 12, DELAY = 4.
1. Reset: hold `rst` low, toggle `in_valid`/`muestra`.
   - Required: `result` = 0, `out_valid` = 0, `out_first` = 0 throughout.
   - Release `rst`, then one idle cycle: outputs stay 0.
2. Basic frame: real 1..8, imag 0, contiguous.
   - First frame, phase 0: `out_valid` = 0 for the first 4 samples.
   - First frame, phase 1: sums 6, 8, 10, 12 (`out_first` on the 6).
   - Second frame, all zeros: first 4 outputs −4, −4, −4, −4 (valid), then sums 0.
3. Extremes:
   - x0 = 2047, x4 = −2048 gives sum −1, and diff 4095 next frame.
   - All −2048 gives sum −4096, diff 0.
   - Imag uses mirrored values and checks the same results independently.
4. Gapped input: same stream as case 2 with `in_valid` toggling in a random pattern.
   - Output value sequence is identical to case 2.
   - `out_valid` is high only on cycles after accepted samples.
5. Reset mid-frame: assert `rst` after 6 samples, then replay case 2.
   - Output is identical to case 2 from the start (no stale diffs, first phase 0 invalid).
6. Long random run: 64 frames of random complex data.
   - Compare against a reference model of the SDF butterfly.
   - `out_first` asserts exactly once per 8 outputs at steady state.
